// File: rtl/ksk_mgr_slot_reader.sv
// Read-side KSK slot controller: finds the slot holding a requested batch, issues RD_NB reads, then releases it.
// Latency: request handshake N -> command valid N+2 on a hit; release pulse one cycle after the final read.
// Backpressure: command held stable until rd_cmd_rdy; one request in flight. Optional checks: KSK_MGR_SLOT_RD_CHECK_EN.
module ksk_mgr_slot_reader #(
   parameter int KSK_SLOT_NB = 8,
   parameter int SLOT_W      = $clog2(KSK_SLOT_NB),
   parameter int BATCH_ID_W  = 8,
   parameter int RD_NB       = 4
) (
   input  logic                   clk,
   input  logic                   s_rst_n,
   input  logic                   wr_fill_vld,
   input  logic [SLOT_W-1:0]      wr_fill_slot,
   input  logic [BATCH_ID_W-1:0]  wr_fill_batch_id,
   input  logic                   rd_req_vld,
   output logic                   rd_req_rdy,
   input  logic [BATCH_ID_W-1:0]  rd_req_batch_id,
   output logic                   rd_cmd_vld,
   input  logic                   rd_cmd_rdy,
   output logic [SLOT_W-1:0]      rd_cmd_slot,
   output logic                   rd_cmd_last,
   output logic                   rel_vld,
   output logic [SLOT_W-1:0]      rel_slot,
   output logic [KSK_SLOT_NB-1:0] slot_filled,
   output logic                   error
);
   localparam int CNT_W = $clog2(RD_NB + 1);

   typedef enum logic [1:0] {IDLE, SEARCH, ISSUE} state_e;

   state_e                  state_q, state_d;
   logic [KSK_SLOT_NB-1:0]  filled_q, filled_d;
   logic [BATCH_ID_W-1:0]   id_q  [KSK_SLOT_NB];
   logic [CNT_W-1:0]        cnt_q [KSK_SLOT_NB];
   logic [BATCH_ID_W-1:0]   req_id_q, req_id_d;
   logic [SLOT_W-1:0]       slot_q, slot_d;
   logic                    last_q, last_d;
   logic                    rdy_q, cmd_vld_q;
   logic                    rel_vld_q, rel_vld_d;
   logic [SLOT_W-1:0]       rel_slot_q, rel_slot_d;
   logic                    hit;
   logic [SLOT_W-1:0]       hit_slot;
   logic                    req_hs, cmd_hs, fill_ok;

   assign req_hs  = rd_req_vld && rdy_q;
   assign cmd_hs  = cmd_vld_q && rd_cmd_rdy;
   // A fill into a slot that is still occupied (even one being released this cycle) is dropped.
   assign fill_ok = wr_fill_vld && !filled_q[wr_fill_slot];

   always_comb begin
      hit      = 1'b0;
      hit_slot = '0;
      for (int i = KSK_SLOT_NB - 1; i >= 0; i--) begin
         if (filled_q[i] && (id_q[i] == req_id_q)) begin
            hit      = 1'b1;
            hit_slot = SLOT_W'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      req_id_d   = req_id_q;
      slot_d     = slot_q;
      last_d     = last_q;
      rel_vld_d  = 1'b0;
      rel_slot_d = rel_slot_q;
      filled_d   = filled_q;
      if (fill_ok) filled_d[wr_fill_slot] = 1'b1;
      case (state_q)
         IDLE: begin
            if (req_hs) begin
               req_id_d = rd_req_batch_id;
               state_d  = SEARCH;
            end
         end
         SEARCH: begin
            if (hit) begin
               slot_d  = hit_slot;
               last_d  = (cnt_q[hit_slot] == CNT_W'(RD_NB - 1));
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_hs) begin
               state_d = IDLE;
               last_d  = 1'b0;
               if (last_q) begin
                  filled_d[slot_q] = 1'b0;
                  rel_vld_d        = 1'b1;
                  rel_slot_d       = slot_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         state_q    <= IDLE;
         filled_q   <= '0;
         req_id_q   <= '0;
         slot_q     <= '0;
         last_q     <= 1'b0;
         rdy_q      <= 1'b0;
         cmd_vld_q  <= 1'b0;
         rel_vld_q  <= 1'b0;
         rel_slot_q <= '0;
         for (int i = 0; i < KSK_SLOT_NB; i++) begin
            id_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         filled_q   <= filled_d;
         req_id_q   <= req_id_d;
         slot_q     <= slot_d;
         last_q     <= last_d;
         rdy_q      <= (state_d == IDLE);
         cmd_vld_q  <= (state_d == ISSUE);
         rel_vld_q  <= rel_vld_d;
         rel_slot_q <= rel_slot_d;
         if (fill_ok) begin
            id_q[wr_fill_slot]  <= wr_fill_batch_id;
            cnt_q[wr_fill_slot] <= '0;
         end
         if (cmd_hs) cnt_q[slot_q] <= cnt_q[slot_q] + CNT_W'(1);
      end
   end

   assign rd_req_rdy  = rdy_q;
   assign rd_cmd_vld  = cmd_vld_q;
   assign rd_cmd_slot = slot_q;
   assign rd_cmd_last = last_q;
   assign rel_vld     = rel_vld_q;
   assign rel_slot    = rel_slot_q;
   assign slot_filled = filled_q;

`ifdef KSK_MGR_SLOT_RD_CHECK_EN
   logic err_q;
   logic multi_hit;
   logic seen;

   always_comb begin
      multi_hit = 1'b0;
      seen      = 1'b0;
      for (int i = 0; i < KSK_SLOT_NB; i++) begin
         if (filled_q[i] && (id_q[i] == req_id_q)) begin
            if (seen) multi_hit = 1'b1;
            seen = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         err_q <= 1'b0;
      end else if ((wr_fill_vld && filled_q[wr_fill_slot]) || ((state_q == SEARCH) && multi_hit)) begin
         err_q <= 1'b1;
      end
   end

   assign error = err_q;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_ksk_mgr_slot_reader.sv
// Scoreboard bench for ksk_mgr_slot_reader: expected commands/releases queued at request time, popped on DUT output.
module tb_ksk_mgr_slot_reader;
   logic       clk = 1'b0;
   logic       s_rst_n;
   logic       wr_fill_vld;
   logic [2:0] wr_fill_slot;
   logic [7:0] wr_fill_batch_id;
   logic       rd_req_vld;
   logic       rd_req_rdy;
   logic [7:0] rd_req_batch_id;
   logic       rd_cmd_vld;
   logic       rd_cmd_rdy;
   logic [2:0] rd_cmd_slot;
   logic       rd_cmd_last;
   logic       rel_vld;
   logic [2:0] rel_slot;
   logic [7:0] slot_filled;
   logic       error;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q[$];   // {slot, last}
   logic [2:0] rel_q[$];
   time        last_hs_t = 0;

   ksk_mgr_slot_reader dut (
      .clk(clk), .s_rst_n(s_rst_n),
      .wr_fill_vld(wr_fill_vld), .wr_fill_slot(wr_fill_slot), .wr_fill_batch_id(wr_fill_batch_id),
      .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_batch_id(rd_req_batch_id),
      .rd_cmd_vld(rd_cmd_vld), .rd_cmd_rdy(rd_cmd_rdy), .rd_cmd_slot(rd_cmd_slot), .rd_cmd_last(rd_cmd_last),
      .rel_vld(rel_vld), .rel_slot(rel_slot), .slot_filled(slot_filled), .error(error)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Scoreboard consumer: a command handshake or release pulse seen here must match the queue head.
   always @(negedge clk) begin
      logic [3:0] e;
      logic [2:0] r;
      if (s_rst_n && rd_cmd_vld && rd_cmd_rdy) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected: got slot=%0d last=%0b, required no command", rd_cmd_slot, rd_cmd_last);
         end else begin
            e = exp_q.pop_front();
            if ({rd_cmd_slot, rd_cmd_last} !== e) begin
               errors++;
               $display("FAIL cmd: got slot=%0d last=%0b, required slot=%0d last=%0b",
                        rd_cmd_slot, rd_cmd_last, e[3:1], e[0]);
            end
         end
         if (rd_cmd_last) last_hs_t = $time;
      end
      if (rel_vld) begin
         checks++;
         if (rel_q.size() == 0) begin
            errors++;
            $display("FAIL rel_unexpected: got rel_slot=%0d, required no release", rel_slot);
         end else begin
            r = rel_q.pop_front();
            if (rel_slot !== r || ($time - last_hs_t) != 10) begin
               errors++;
               $display("FAIL rel: got slot=%0d delay=%0t, required slot=%0d delay=10", rel_slot, $time - last_hs_t, r);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [2:0] slot, input logic [7:0] id);
      wr_fill_vld      = 1'b1;
      wr_fill_slot     = slot;
      wr_fill_batch_id = id;
      tick();
      wr_fill_vld      = 1'b0;
   endtask

   task automatic send_req(input logic [7:0] id);
      bit done = 0;
      rd_req_vld      = 1'b1;
      rd_req_batch_id = id;
      for (int i = 0; i < 40 && !done; i++) begin
         done = rd_req_rdy;
         tick();
      end
      rd_req_vld = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL req_accept: got rd_req_rdy=0 for 40 cycles, required acceptance");
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60 && (exp_q.size() != 0 || rel_q.size() != 0); i++) tick();
      checks++;
      if (exp_q.size() != 0 || rel_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d cmds %0d rels outstanding, required 0", exp_q.size(), rel_q.size());
      end
   endtask

   task automatic test_reset();
      s_rst_n = 1'b0;
      wr_fill_vld = 1'b0; wr_fill_slot = '0; wr_fill_batch_id = '0;
      rd_req_vld = 1'b0; rd_req_batch_id = '0; rd_cmd_rdy = 1'b1;
      tick(); tick();
      @(negedge clk);
      checks++;
      if ({rd_req_rdy, rd_cmd_vld, rd_cmd_last, rel_vld, error} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy/vld/last/rel/err=%b, required 00000",
                  {rd_req_rdy, rd_cmd_vld, rd_cmd_last, rel_vld, error});
      end
      checks++;
      if ({rd_cmd_slot, rel_slot, slot_filled} !== 14'b0) begin
         errors++;
         $display("FAIL reset_data: got cmd_slot=%0d rel_slot=%0d filled=%b, required 0",
                  rd_cmd_slot, rel_slot, slot_filled);
      end
      tick();
      s_rst_n = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if (rd_req_rdy !== 1'b1) begin
         errors++;
         $display("FAIL rdy_after_reset: got %b, required 1", rd_req_rdy);
      end
      tick();
   endtask

   task automatic test_single_batch();
      fill(3'd3, 8'h21);
      @(negedge clk);
      checks++;
      if (slot_filled !== 8'b0000_1000) begin
         errors++;
         $display("FAIL fill_visible: got filled=%b, required 00001000", slot_filled);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({3'd3, k == 3});
         if (k == 3) rel_q.push_back(3'd3);
         send_req(8'h21);
         if (k == 0) begin
            @(negedge clk);
            checks++;
            if (rd_cmd_vld !== 1'b0 || rd_req_rdy !== 1'b0) begin
               errors++;
               $display("FAIL search_cycle: got vld=%b rdy=%b, required vld=0 rdy=0", rd_cmd_vld, rd_req_rdy);
            end
            tick();
            @(negedge clk);
            checks++;
            if (rd_cmd_vld !== 1'b1) begin
               errors++;
               $display("FAIL cmd_latency: got vld=%b at N+2, required 1", rd_cmd_vld);
            end
            tick();
         end
      end
      wait_drain();
      @(negedge clk);
      checks++;
      if (slot_filled !== 8'b0) begin
         errors++;
         $display("FAIL release_clear: got filled=%b, required 00000000", slot_filled);
      end
      tick();
   endtask

   task automatic test_req_before_fill();
      bit seen_vld = 0;
      exp_q.push_back({3'd6, 1'b0});
      send_req(8'h05);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rd_cmd_vld) seen_vld = 1;
         tick();
      end
      checks++;
      if (seen_vld) begin
         errors++;
         $display("FAIL miss_hold: got rd_cmd_vld=1 with no matching slot, required 0");
      end
      fill(3'd6, 8'h05);
      @(negedge clk);
      checks++;
      if (rd_cmd_vld !== 1'b0) begin
         errors++;
         $display("FAIL fill_plus1: got vld=%b, required 0", rd_cmd_vld);
      end
      tick();
      @(negedge clk);
      checks++;
      if (rd_cmd_vld !== 1'b1 || rd_cmd_slot !== 3'd6) begin
         errors++;
         $display("FAIL fill_plus2: got vld=%b slot=%0d, required vld=1 slot=6", rd_cmd_vld, rd_cmd_slot);
      end
      tick();
      wait_drain();
   endtask

   task automatic test_backpressure();
      bit stable = 1;
      bit got = 0;
      rd_cmd_rdy = 1'b0;
      exp_q.push_back({3'd6, 1'b0});
      send_req(8'h05);
      for (int i = 0; i < 10 && !got; i++) begin
         got = rd_cmd_vld;
         if (!got) tick();
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL bp_vld: got rd_cmd_vld=0 for 10 cycles, required 1");
      end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if ({rd_cmd_vld, rd_cmd_slot, rd_cmd_last} !== {1'b1, 3'd6, 1'b0}) stable = 0;
         tick();
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL bp_stable: got vld/slot/last=%b/%0d/%b, required 1/6/0", rd_cmd_vld, rd_cmd_slot, rd_cmd_last);
      end
      rd_cmd_rdy = 1'b1;
      wait_drain();
      // Two reads remain if the counter did not move while stalled.
      exp_q.push_back({3'd6, 1'b0});
      send_req(8'h05);
      exp_q.push_back({3'd6, 1'b1});
      rel_q.push_back(3'd6);
      send_req(8'h05);
      wait_drain();
   endtask

   task automatic test_interleave();
      fill(3'd0, 8'h10);
      fill(3'd1, 8'h11);
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back({3'(k % 2), k >= 6});
         if (k >= 6) rel_q.push_back(3'(k % 2));
         send_req((k % 2 == 0) ? 8'h10 : 8'h11);
      end
      wait_drain();
      @(negedge clk);
      checks++;
      if (slot_filled !== 8'b0) begin
         errors++;
         $display("FAIL interleave_clear: got filled=%b, required 00000000", slot_filled);
      end
      tick();
   endtask

   task automatic test_dup_fill();
      logic exp_err;
`ifdef KSK_MGR_SLOT_RD_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      fill(3'd2, 8'h33);
      @(negedge clk);
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL err_before_dup: got %b, required 0", error);
      end
      tick();
      fill(3'd2, 8'h44);
      @(negedge clk);
      checks++;
      if (error !== exp_err) begin
         errors++;
         $display("FAIL dup_err: got %b, required %b", error, exp_err);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({3'd2, k == 3});
         if (k == 3) rel_q.push_back(3'd2);
         send_req(8'h33);
      end
      wait_drain();
      @(negedge clk);
      checks++;
      if (error !== exp_err) begin
         errors++;
         $display("FAIL dup_err_sticky: got %b, required %b", error, exp_err);
      end
      tick();
   endtask

   task automatic test_reset_mid_issue();
      bit got = 0;
      bit quiet = 1;
      fill(3'd5, 8'h55);
      rd_cmd_rdy = 1'b0;
      send_req(8'h55);
      for (int i = 0; i < 10 && !got; i++) begin
         got = rd_cmd_vld;
         if (!got) tick();
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL rst_issue_vld: got rd_cmd_vld=0, required 1 before reset");
      end
      s_rst_n = 1'b0;
      tick();
      s_rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      checks++;
      if ({rd_req_rdy, rd_cmd_vld, rd_cmd_slot, rd_cmd_last, rel_vld, rel_slot, slot_filled, error} !== 18'b0) begin
         errors++;
         $display("FAIL rst_mid: got rdy=%b vld=%b slot=%0d last=%b rel=%b rel_slot=%0d filled=%b err=%b, required all 0",
                  rd_req_rdy, rd_cmd_vld, rd_cmd_slot, rd_cmd_last, rel_vld, rel_slot, slot_filled, error);
      end
      rd_cmd_rdy = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rel_vld || rd_cmd_vld) quiet = 0;
         tick();
      end
      checks++;
      if (!quiet || rd_req_rdy !== 1'b1) begin
         errors++;
         $display("FAIL rst_drop: got quiet=%b rdy=%b, required quiet=1 rdy=1", quiet, rd_req_rdy);
      end
   endtask

   initial begin
      test_reset();
      test_single_batch();
      test_req_before_fill();
      test_backpressure();
      test_interleave();
      test_dup_fill();
      test_reset_mid_issue();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
